// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave port between the instruction
// fetch requester (inst) and the data requester (data). Every accepted address
// records its owner in an in-order ID queue, and each returning response is
// routed to the owner of the oldest outstanding transaction.
// Optional feature: define ARB_RR_EN for round-robin tie breaking; when it is
// undefined the data requester always wins ties.
module sram_like_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,

    output logic        resp_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // The lock holds the grant on a request the slave has not yet accepted.
    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lock_state_t;

    lock_state_t       lock_state;
    lock_state_t       lock_state_next;
    logic              lock_id;
    logic              lock_id_next;

    logic [DEPTH-1:0]  id_mem;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              queue_full;
    logic              queue_empty;
    logic              grant_valid;
    logic              grant_id;
    logic              push;
    logic              pop;
    logic              head_id;

`ifdef ARB_RR_EN
    logic              last;
`endif

    assign queue_full  = (count == FULL_COUNT);
    assign queue_empty = (count == '0);
    assign head_id     = id_mem[rd_ptr];

    // Pick the requester that owns the slave port this cycle (0=inst, 1=data).
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (lock_state == LOCK_HELD) begin
            grant_id    = lock_id;
            grant_valid = lock_id ? data_req : inst_req;
        end else begin
`ifdef ARB_RR_EN
            if (inst_req && data_req) begin
                grant_valid = 1'b1;
                grant_id    = ~last;
            end else if (data_req) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end else if (inst_req) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
`else
            if (data_req) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end else if (inst_req) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
`endif
        end
    end

    // Forward the granted request to the slave, blocked while the queue is full.
    always_comb begin
        s_req   = grant_valid && !queue_full;
        s_wr    = 1'b0;
        s_size  = 2'd0;
        s_wstrb = 4'd0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        if (s_req) begin
            if (grant_id) begin
                s_wr    = data_wr;
                s_size  = data_size;
                s_wstrb = data_wstrb;
                s_addr  = data_addr;
                s_wdata = data_wdata;
            end else begin
                s_wr    = inst_wr;
                s_size  = inst_size;
                s_wstrb = inst_wstrb;
                s_addr  = inst_addr;
                s_wdata = inst_wdata;
            end
        end
    end

    assign push         = s_req && s_addr_ok;
    assign pop          = s_data_ok && !queue_empty;
    assign inst_addr_ok = push && !grant_id;
    assign data_addr_ok = push && grant_id;
    assign inst_data_ok = pop && !head_id;
    assign data_data_ok = pop && head_id;
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;

    // Engage the lock on an unaccepted request; freeze it while the queue is full.
    always_comb begin
        lock_state_next = lock_state;
        lock_id_next    = lock_id;
        if (!queue_full) begin
            if (s_req && !s_addr_ok) begin
                lock_state_next = LOCK_HELD;
                lock_id_next    = grant_id;
            end else begin
                lock_state_next = LOCK_IDLE;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= LOCK_IDLE;
            lock_id    <= 1'b0;
        end else begin
            lock_state <= lock_state_next;
            lock_id    <= lock_id_next;
        end
    end

    // ID storage; contents are only meaningful between wr_ptr and rd_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_id;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (s_data_ok && queue_empty) begin
            resp_err <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    // Remember who was accepted last so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (push) begin
            last <= grant_id;
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed scenarios with literal expectations
// plus a long randomized run, all compared every cycle against a queue-based
// behavioural model. Honours ARB_RR_EN the same way as the design.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owners of outstanding transactions, oldest first.
    bit mq[$];
    bit m_lock, m_lock_id, m_last, m_err;
    bit e_full, e_sreq, e_gid;

    sram_like_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .resp_err(resp_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ireq, input bit dreq,
                                 input logic [31:0] iaddr, input logic [31:0] daddr,
                                 input bit aok, input bit dok, input logic [31:0] rdata);
        reset      = rst;
        inst_req   = ireq;
        data_req   = dreq;
        inst_addr  = iaddr;
        data_addr  = daddr;
        inst_wr    = 1'($urandom);
        data_wr    = 1'($urandom);
        inst_size  = 2'($urandom_range(0, 2));
        data_size  = 2'($urandom_range(0, 2));
        inst_wstrb = 4'($urandom);
        data_wstrb = 4'($urandom);
        inst_wdata = $urandom;
        data_wdata = $urandom;
        s_addr_ok  = aok;
        s_data_ok  = dok;
        s_rdata    = rdata;
        #1;
    endtask

    // Compare every DUT output with what the model says this cycle must show.
    task automatic checkOutput();
        bit gv, head, epop;
        gv    = 1'b0;
        e_gid = 1'b0;
        e_full = (mq.size() == DEPTH);
        if (m_lock) begin
            e_gid = m_lock_id;
            gv    = m_lock_id ? data_req : inst_req;
        end else if (inst_req && data_req) begin
            gv = 1'b1;
`ifdef ARB_RR_EN
            e_gid = !m_last;
`else
            e_gid = 1'b1;
`endif
        end else if (data_req) begin
            gv = 1'b1; e_gid = 1'b1;
        end else if (inst_req) begin
            gv = 1'b1; e_gid = 1'b0;
        end
        e_sreq = gv && !e_full;
        head   = (mq.size() > 0) ? mq[0] : 1'b0;
        epop   = s_data_ok && (mq.size() > 0);

        checkBit("s_req", s_req, e_sreq);
        checkBit("s_wr", s_wr, e_sreq && (e_gid ? data_wr : inst_wr));
        checkWord("s_size", {30'd0, s_size}, e_sreq ? {30'd0, (e_gid ? data_size : inst_size)} : 32'd0);
        checkWord("s_wstrb", {28'd0, s_wstrb}, e_sreq ? {28'd0, (e_gid ? data_wstrb : inst_wstrb)} : 32'd0);
        checkWord("s_addr", s_addr, e_sreq ? (e_gid ? data_addr : inst_addr) : 32'd0);
        checkWord("s_wdata", s_wdata, e_sreq ? (e_gid ? data_wdata : inst_wdata) : 32'd0);
        checkBit("inst_addr_ok", inst_addr_ok, e_sreq && s_addr_ok && !e_gid);
        checkBit("data_addr_ok", data_addr_ok, e_sreq && s_addr_ok && e_gid);
        checkBit("inst_data_ok", inst_data_ok, epop && !head);
        checkBit("data_data_ok", data_data_ok, epop && head);
        checkWord("inst_rdata", inst_rdata, s_rdata);
        checkWord("data_rdata", data_rdata, s_rdata);
        checkBit("resp_err", resp_err, m_err);
    endtask

    // Move the model across the clock edge, then wait for that edge.
    task automatic advance();
        if (reset) begin
            mq.delete();
            m_lock = 1'b0; m_lock_id = 1'b0; m_last = 1'b1; m_err = 1'b0;
        end else begin
            if (s_data_ok && mq.size() == 0) m_err = 1'b1;
            if (s_data_ok && mq.size() > 0) void'(mq.pop_front());
            if (e_sreq && s_addr_ok) begin
                mq.push_back(e_gid);
                m_last = e_gid;
            end
            if (!e_full) begin
                m_lock = e_sreq && !s_addr_ok;
                if (m_lock) m_lock_id = e_gid;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input bit rst, input bit ireq, input bit dreq,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input bit aok, input bit dok, input logic [31:0] rdata);
        applyStimulus(rst, ireq, dreq, iaddr, daddr, aok, dok, rdata);
        checkOutput();
        advance();
    endtask

    initial begin
        bit ir, dr, ak, dk;
        applyStimulus(1'b1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        mq.delete();
        m_lock = 1'b0; m_lock_id = 1'b0; m_last = 1'b1; m_err = 1'b0;

        // Values right after reset.
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        checkOutput();
        checkBit("rst_s_req", s_req, 1'b0);
        checkWord("rst_s_addr", s_addr, 32'd0);
        checkBit("rst_addr_ok", inst_addr_ok | data_addr_ok, 1'b0);
        checkBit("rst_resp_err", resp_err, 1'b0);
        advance();

        // Single instruction read.
        applyStimulus(0, 1, 0, 32'hbfc00000, 32'd0, 1, 0, 32'd0);
        checkOutput();
        checkBit("t1_inst_addr_ok", inst_addr_ok, 1'b1);
        checkWord("t1_s_addr", s_addr, 32'hbfc00000);
        advance();
        cycle(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'h3c1d0000);
        checkOutput();
        checkBit("t1_inst_data_ok", inst_data_ok, 1'b1);
        checkWord("t1_inst_rdata", inst_rdata, 32'h3c1d0000);
        checkBit("t1_data_data_ok", data_data_ok, 1'b0);
        advance();

        // Conflict between both requesters.
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
`ifdef ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 1, 32'h1000, 32'h2000, 1, 0, 32'd0);
            checkOutput();
            checkBit("rr_inst_addr_ok", inst_addr_ok, (k % 2) == 0);
            checkBit("rr_data_addr_ok", data_addr_ok, (k % 2) == 1);
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'h100 + 32'(k));
            checkOutput();
            checkBit("rr_inst_data_ok", inst_data_ok, (k % 2) == 0);
            checkBit("rr_data_data_ok", data_data_ok, (k % 2) == 1);
            advance();
        end
`else
        applyStimulus(0, 1, 1, 32'h1000, 32'h2000, 1, 0, 32'd0);
        checkOutput();
        checkBit("fp_data_first", data_addr_ok, 1'b1);
        checkBit("fp_inst_wait", inst_addr_ok, 1'b0);
        advance();
        applyStimulus(0, 1, 0, 32'h1000, 32'h2000, 1, 0, 32'd0);
        checkOutput();
        checkBit("fp_inst_second", inst_addr_ok, 1'b1);
        advance();
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'haaaa0000);
        checkOutput();
        checkBit("fp_r0_data", data_data_ok, 1'b1);
        checkBit("fp_r0_inst", inst_data_ok, 1'b0);
        advance();
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'hbbbb0000);
        checkOutput();
        checkBit("fp_r1_inst", inst_data_ok, 1'b1);
        checkBit("fp_r1_data", data_data_ok, 1'b0);
        advance();
`endif

        // Lock holds the inst request until the slave accepts it.
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, k > 0, 32'h00400000, 32'h80001000, 0, 0, 32'd0);
            checkOutput();
            checkWord("lk_s_addr", s_addr, 32'h00400000);
            checkBit("lk_s_req", s_req, 1'b1);
            advance();
        end
        applyStimulus(0, 1, 1, 32'h00400000, 32'h80001000, 1, 0, 32'd0);
        checkOutput();
        checkBit("lk_inst_accept", inst_addr_ok, 1'b1);
        checkBit("lk_data_hold", data_addr_ok, 1'b0);
        advance();
        applyStimulus(0, 0, 1, 32'h00400000, 32'h80001000, 1, 0, 32'd0);
        checkOutput();
        checkBit("lk_data_accept", data_addr_ok, 1'b1);
        advance();
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'h11111111);
        checkOutput();
        checkBit("lk_resp_inst", inst_data_ok, 1'b1);
        advance();
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'h22222222);
        checkOutput();
        checkBit("lk_resp_data", data_data_ok, 1'b1);
        advance();

        // Full queue gating and simultaneous push/pop.
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 32'h3000 + 32'(4 * k), 32'd0, 1, 0, 32'd0);
            checkOutput();
            checkBit("fl_fill", inst_addr_ok, 1'b1);
            advance();
        end
        applyStimulus(0, 1, 0, 32'h3010, 32'd0, 1, 0, 32'd0);
        checkOutput();
        checkBit("fl_blocked", s_req, 1'b0);
        checkBit("fl_no_ok", inst_addr_ok, 1'b0);
        advance();
        applyStimulus(0, 1, 0, 32'h3010, 32'd0, 1, 1, 32'h5);
        checkOutput();
        checkBit("fl_pop_still_blocked", s_req, 1'b0);
        checkBit("fl_pop_resp", inst_data_ok, 1'b1);
        advance();
        applyStimulus(0, 1, 0, 32'h3010, 32'd0, 1, 0, 32'd0);
        checkOutput();
        checkBit("fl_unblocked", s_req, 1'b1);
        advance();
        cycle(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'h6);
        cycle(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'h7);
        applyStimulus(0, 1, 0, 32'h3014, 32'd0, 1, 1, 32'h8);
        checkOutput();
        checkBit("pp_push", inst_addr_ok, 1'b1);
        checkBit("pp_pop", inst_data_ok, 1'b1);
        advance();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 0, 32'h3018, 32'd0, 1, 0, 32'd0);
            checkOutput();
            checkBit("pp_refill", inst_addr_ok, 1'b1);
            advance();
        end
        applyStimulus(0, 1, 0, 32'h3020, 32'd0, 1, 0, 32'd0);
        checkOutput();
        checkBit("pp_full_again", s_req, 1'b0);
        advance();

        // Reset with transactions outstanding.
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        cycle(0, 1, 0, 32'h4000, 32'd0, 1, 0, 32'd0);
        cycle(0, 0, 1, 32'd0, 32'h4004, 1, 0, 32'd0);
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 1, 32'hdead);
        checkOutput();
        checkBit("ro_no_inst_ok", inst_data_ok, 1'b0);
        checkBit("ro_no_data_ok", data_data_ok, 1'b0);
        advance();
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        checkOutput();
        checkBit("ro_err_set", resp_err, 1'b1);
        advance();
        applyStimulus(0, 1, 1, 32'h5000, 32'h6000, 1, 0, 32'd0);
        checkOutput();
        checkBit("ro_err_sticky", resp_err, 1'b1);
        advance();
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
        checkOutput();
        checkBit("ro_err_cleared", resp_err, 1'b0);
        advance();

        // Randomized traffic; a locked requester keeps its request up.
        for (int n = 0; n < 3000; n++) begin
            ir = ($urandom_range(0, 9) < 6);
            dr = ($urandom_range(0, 9) < 6);
            if (m_lock && !m_lock_id) ir = 1'b1;
            if (m_lock && m_lock_id)  dr = 1'b1;
            ak = ($urandom_range(0, 9) < 7);
            dk = (mq.size() > 0) && ($urandom_range(0, 9) < 6);
            cycle($urandom_range(0, 499) == 0, ir, dr, $urandom, $urandom, ak, dk, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter that shares one sram-like slave port between the instruction-fetch requester (if_stage) and the data requester (exe/mem stages). It forwards one granted request per cycle and records the requester of every accepted address in an in-order ID queue. It then routes each returning `data_ok`/`rdata` to the requester that owns the oldest accepted transaction. It sits between the CPU pipeline and the cache/AXI bridge.

## Interface
Parameters:
- `DEPTH`, 4: maximum outstanding (addr accepted, data not yet returned) transactions; power of two, 2..16.

Ports (`X` = `inst` or `data`; both groups are identical). The clock is `clk`. Reset is `reset`: synchronous, active-high.
- `clk  input  1  clock`
- `reset  input  1  synchronous active-high reset`
- `X_req, X_wr  input  1  requester request / write flag`
- `X_size  input  2  transfer size (0:1B, 1:2B, 2:4B)`
- `X_wstrb  input  4  byte write strobes`
- `X_addr, X_wdata  input  32  address / write data`
- `X_addr_ok, X_data_ok  output  1  address accepted / response for this requester`
- `X_rdata  output  32  read data (copy of s_rdata)`
- `s_req, s_wr  output  1  slave request / write flag`
- `s_size  output  2; s_wstrb  output  4; s_addr, s_wdata  output  32  muxed from granted requester`
- `s_addr_ok, s_data_ok  input  1  slave handshakes`
- `s_rdata  input  32  slave read data`
- `resp_err  output  1  sticky: s_data_ok received with empty ID queue`

## Operation
- Grant selection:
  - If `lock` is set, the grant stays at `lock_id`.
  - Otherwise `data` wins when `data_req`=1, else `inst` wins when `inst_req`=1.
  - Round-robin replaces this rule when it is compiled in (see Configuration).
- Queue-full gating: when `count==DEPTH`, `s_req`=0 and the `lock` state is held. A pop in the same cycle does not unblock the queue until the next cycle.
- Forwarding:
  - `s_req`, `s_wr`, `s_size`, `s_wstrb`, `s_addr` and `s_wdata` come from the granted requester.
  - All `s_*` outputs are 0 when no requester is granted.
- Address accept: on `s_req && s_addr_ok`, only the granted requester sees `X_addr_ok`=1. Its ID (0=inst, 1=data) is pushed at `wr_ptr`.
- Lock: `lock` is set when `s_req && !s_addr_ok`, with `lock_id` = current grant. It clears on `s_addr_ok`. This keeps the slave request stable until it is accepted.
- Response: on `s_data_ok` with `count>0`, the head ID is popped.
  - `inst_data_ok` = `s_data_ok && head==0`.
  - `data_data_ok` = `s_data_ok && head==1`.
  - `X_rdata` = `s_rdata` for both requesters, unconditionally.
- ID queue: circular buffer of `DEPTH` one-bit entries.
  - `rd_ptr` and `wr_ptr` are log2(`DEPTH`) bits wide and wrap modulo `DEPTH`.
  - `count` is log2(`DEPTH`)+1 bits wide.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Unexpected response: `s_data_ok` with `count==0` produces no `X_data_ok`, leaves the queue unchanged and sets `resp_err`. `resp_err` clears only on reset.
- Reset (including mid-transaction):
  - Clears `count`, both pointers, `lock` and `resp_err`.
  - Responses still in flight at reset are treated as unexpected.

## Timing
- Request path is combinational: `X_req` → `s_req` and `s_addr_ok` → `X_addr_ok` have zero latency.
- Response path is combinational from the registered queue head: `s_data_ok` → `X_data_ok` has zero latency.
- Queue state, `lock` and `resp_err` update on the rising edge of `clk`.
- Throughput is one address accept and one response per cycle.
- A response can be returned in the cycle after its address is accepted. A response can never be returned in the same cycle as its own address acceptance, because the slave requires this ordering.
- Values after reset:
  - `count`=0 and `lock`=0.
  - `s_*` follow the requesters' inputs through the grant logic; with both `X_req`=0 they are 0.
  - `X_addr_ok`=`X_data_ok`=0 and `resp_err`=0.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last` register records the ID of the last accepted request.
  - When both requesters request and `lock`=0, the requester that is not `last` is granted. `last` resets to 1 (inst wins the first tie).
- `ARB_RR_EN` undefined: fixed priority, `data` always wins ties, and the `last` register is absent.

## Test plan
- Single inst read: `inst_req`=1, `inst_addr`=0xbfc00000; `s_addr_ok` in cycle 0, `s_data_ok` in cycle 2 with `s_rdata`=0x3c1d0000 → `inst_addr_ok`=1 in cycle 0; `inst_data_ok`=1 with `inst_rdata`=0x3c1d0000 in cycle 2; `data_data_ok` stays 0.
- Conflict (`ARB_RR_EN` undefined): both requesters request in the same cycle with `s_addr_ok`=1 → data is accepted first, inst the next cycle. Responses R0 and R1 route to `data_data_ok` then `inst_data_ok`, in that order.
- Conflict (`ARB_RR_EN` defined): both requesters held high for 4 cycles with `s_addr_ok`=1 → accept order inst, data, inst, data.
- Lock: `inst_req`=1 with `s_addr_ok`=0 for 3 cycles while `data_req` rises in cycle 1 → `s_addr`=`inst_addr` for all 3 cycles; data is granted only after inst's `s_addr_ok`.
- Full: `DEPTH`=4, accept 4 addresses with no response → `s_req`=0 in the 5th cycle. After one `s_data_ok`, `s_req` is 1 again in the following cycle. Simultaneous push and pop at `count`=2 leaves `count`=2.
- Reset mid-operation: reset with 2 outstanding, then `s_data_ok` → no `X_data_ok`, `resp_err`=1 until the next reset.
